// File: rtl/uart_buffered.sv
// uart_buffered: buffered full-duplex UART with valid/ready CPU channels and TX/RX FIFOs
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready   CPU -> TX FIFO push handshake
//   rx_data/rx_valid/rx_ready   RX FIFO -> CPU pop handshake (first-word fall-through)
//   tx_count, rx_count          FIFO occupancies 0..FIFO_DEPTH
//   rx_overrun, rx_frame_err,   one-cycle error pulses; each dropped frame raises at most one
//   rx_parity_err
//   serial_in, serial_out       serial pins; serial_in is asynchronous, serial_out idles high
// Build option: define PARITY_EN to add an even-parity bit after the data bits in both directions.

module uart_buffered_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wp_d  = wp_q + PW'(push_i);
    rp_d  = rp_q + PW'(pop_i);
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

module uart_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            rx_overrun,
  output logic                            rx_frame_err,
  output logic                            rx_parity_err,
  input  logic                            serial_in,
  output logic                            serial_out
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic                 tx_full, tx_empty, tx_pop, tx_load, tx_bit_end, tx_last, rdy_q;
  logic [DATA_BITS-1:0] tx_head;
  state_e               tx_st_q, tx_st_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS:0]   tx_sh_q, tx_sh_d;
  logic                 tx_line_q, tx_line_d;

  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_bit_end, rx_last, fall;
  logic                 s1_q, s2_q, prev_q;
  state_e               rx_st_q, rx_st_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 ov_q, ov_d, fe_q, fe_d, pe_q, pe_d;

  // tx_ready stays low until the first edge after reset release
  assign tx_ready = rdy_q && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;

  uart_buffered_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_valid && tx_ready), .din_i(tx_data), .pop_i(tx_pop),
    .dout_o(tx_head), .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_buffered_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .din_i(rx_sh_q), .pop_i(rx_pop),
    .dout_o(rx_data), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign tx_bit_end = tx_cnt_q == CW'(CLKS_PER_BIT-1);
  assign tx_last    = tx_bit_q == BW'(DATA_BITS-1);

  // The shift register carries the parity bit above the data, so it is on bit 0 after the data bits
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q + CW'(1);
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_line_d = tx_line_q;
    tx_load   = 1'b0;
    case (tx_st_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_load  = !tx_empty;
      end
      START: if (tx_bit_end) begin
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_st_d   = DATA;
        tx_line_d = tx_sh_q[0];
      end
      DATA: if (tx_bit_end) begin
        tx_cnt_d  = '0;
        tx_sh_d   = tx_sh_q >> 1;
        tx_bit_d  = tx_bit_q + BW'(1);
        tx_line_d = (tx_last && !PAR) ? 1'b1 : tx_sh_q[1];
        tx_st_d   = tx_last ? (PAR ? PARITY : STOP) : DATA;
      end
      PARITY: if (tx_bit_end) begin
        tx_cnt_d  = '0;
        tx_st_d   = STOP;
        tx_line_d = 1'b1;
      end
      STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_st_d  = IDLE;
        tx_load  = !tx_empty;
      end
      default: tx_st_d = IDLE;
    endcase
    // Loading straight out of STOP gives back-to-back frames with no idle gap
    tx_pop = tx_load;
    if (tx_load) begin
      tx_sh_d   = {^tx_head, tx_head};
      tx_st_d   = START;
      tx_line_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      tx_st_q   <= IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_line_q <= 1'b1;
    end else begin
      rdy_q     <= 1'b1;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_line_q <= tx_line_d;
    end

  assign serial_out = tx_line_q;

  assign fall       = prev_q && !s2_q;
  assign rx_bit_end = rx_cnt_q == CW'(CLKS_PER_BIT-1);
  assign rx_last    = rx_bit_q == BW'(DATA_BITS-1);

  // Start bit is re-checked at half a bit; later samples land one full bit apart, at bit centres
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ov_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_st_d  = fall ? START : IDLE;
      end
      START: if (rx_cnt_q == CW'(CLKS_PER_BIT/2)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = s2_q ? IDLE : DATA;
      end
      DATA: if (rx_bit_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {s2_q, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + BW'(1);
        rx_st_d  = rx_last ? (PAR ? PARITY : STOP) : DATA;
      end
      PARITY: if (rx_bit_end) begin
        rx_cnt_d = '0;
        pe_d     = s2_q != ^rx_sh_q;
        rx_st_d  = pe_d ? IDLE : STOP;
      end
      STOP: if (rx_bit_end) begin
        rx_cnt_d = '0;
        rx_st_d  = IDLE;
        fe_d     = !s2_q;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the frame
        ov_d     = s2_q && rx_full && !rx_pop;
        rx_push  = s2_q && !ov_d;
      end
      default: rx_st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      rx_st_q  <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      ov_q     <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      s1_q     <= serial_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      ov_q     <= ov_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
    end

  assign rx_overrun    = ov_q;
  assign rx_frame_err  = fe_q;
  assign rx_parity_err = PAR && pe_q;
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: directed scoreboard bench for uart_buffered (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4)
module tb_uart_buffered;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int D   = 4;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [2:0]    tx_count, rx_count;
  logic          rx_overrun, rx_frame_err, rx_parity_err;
  logic          serial_in, serial_out;
  logic          drv = 1'b1;
  logic          loop_en = 1'b0;

  int errors = 0;
  int checks = 0;
  int ov_n = 0;
  int fe_n = 0;
  int pe_n = 0;
  logic [DB-1:0] exp_q[$];

  assign serial_in = loop_en ? serial_out : drv;

  always #5 clk = ~clk;

  uart_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .serial_in(serial_in), .serial_out(serial_out)
  );

  always @(negedge clk)
    if (rst_n) begin
      ov_n += int'(rx_overrun);
      fe_n += int'(rx_frame_err);
      pe_n += int'(rx_parity_err);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DB-1:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      cyc(1);
      n++;
    end
    if (!tx_ready) chk("push_ready_timeout", 32'(tx_ready), 1);
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic send(input logic [DB-1:0] b, input logic stop, input logic par_flip);
    drv = 1'b0;
    cyc(CPB);
    for (int i = 0; i < DB; i++) begin
      drv = b[i];
      cyc(CPB);
    end
    if (PAR) begin
      drv = (^b) ^ par_flip;
      cyc(CPB);
    end
    drv = stop;
    cyc(CPB);
    drv = 1'b1;
  endtask

  task automatic pop_chk(input string tag);
    int n = 0;
    logic [DB-1:0] e;
    while (!rx_valid && n < 4000) begin
      cyc(1);
      n++;
    end
    if (!rx_valid) chk({tag, "_valid_timeout"}, 32'(rx_valid), 1);
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, 32'(rx_data), 32'(e));
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame;
    int nb;
    int n;
    #12;
    chk("rst_serial_out", 32'(serial_out), 1);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_err", {29'b0, rx_overrun, rx_frame_err, rx_parity_err}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_tx_ready_pre", 32'(tx_ready), 0);
    cyc(1);
    chk("rel_tx_ready_post", 32'(tx_ready), 1);

    // TX waveform of 0xA5, every bit checked on its first and last cycle
    push(8'hA5);
    chk("a5_count_e", 32'(tx_count), 1);
    chk("a5_idle_e", 32'(serial_out), 1);
    cyc(1);
    frame = PAR ? {1'b1, ^8'hA5, 8'hA5, 1'b0} : {1'b0, 1'b1, 8'hA5, 1'b0};
    nb = PAR ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      chk($sformatf("a5_bit%0d_first", b), 32'(serial_out), 32'(frame[b]));
      cyc(CPB - 1);
      chk($sformatf("a5_bit%0d_last", b), 32'(serial_out), 32'(frame[b]));
      cyc(1);
    end
    chk("a5_idle_after", 32'(serial_out), 1);
    chk("a5_count_end", 32'(tx_count), 0);

    // Loopback of four back-to-back frames with the consumer stalled
    loop_en = 1'b1;
    push(8'h00); exp_q.push_back(8'h00);
    push(8'hFF); exp_q.push_back(8'hFF);
    push(8'h3C); exp_q.push_back(8'h3C);
    push(8'h81); exp_q.push_back(8'h81);
    n = 0;
    while (rx_count != 3'd4 && n < 3000) begin
      cyc(1);
      n++;
    end
    chk("lb_rx_count_peak", 32'(rx_count), 4);
    cyc(2 * CPB);
    chk("lb_rx_count_hold", 32'(rx_count), 4);
    chk("lb_no_overrun", 32'(ov_n), 0);
    chk("lb_no_frame_err", 32'(fe_n), 0);
    chk("lb_no_parity_err", 32'(pe_n), 0);
    pop_chk("lb_pop0");
    pop_chk("lb_pop1");
    pop_chk("lb_pop2");
    pop_chk("lb_pop3");
    chk("lb_rx_count_end", 32'(rx_count), 0);
    chk("lb_rx_valid_end", 32'(rx_valid), 0);
    loop_en = 1'b0;

    // Five injected frames into a four-entry FIFO: the fifth is dropped
    for (int k = 1; k <= 5; k++) begin
      send(8'(k * 8'h11), 1'b1, 1'b0);
      if (k < 5) exp_q.push_back(8'(k * 8'h11));
    end
    cyc(4);
    chk("ov_rx_count", 32'(rx_count), 4);
    chk("ov_pulse_count", 32'(ov_n), 1);
    chk("ov_no_frame_err", 32'(fe_n), 0);
    pop_chk("ov_pop0");
    pop_chk("ov_pop1");
    pop_chk("ov_pop2");
    pop_chk("ov_pop3");
    chk("ov_rx_count_end", 32'(rx_count), 0);

    // Good frame, then a frame with a low stop bit, then a short glitch
    send(8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    send(8'h55, 1'b0, 1'b0);
    cyc(CPB);
    chk("fe_pulse_count", 32'(fe_n), 1);
    chk("fe_rx_count", 32'(rx_count), 1);
    drv = 1'b0;
    cyc(4);
    drv = 1'b1;
    cyc(3 * CPB);
    chk("glitch_rx_count", 32'(rx_count), 1);
    chk("glitch_fe_count", 32'(fe_n), 1);
    chk("glitch_ov_count", 32'(ov_n), 1);
    pop_chk("fe_pop_good");

`ifdef PARITY_EN
    loop_en = 1'b1;
    push(8'h07);
    exp_q.push_back(8'h07);
    cyc(1 + CPB * 9 + CPB / 2);
    chk("par_wire_bit", 32'(serial_out), 1);
    pop_chk("par_lb_pop");
    loop_en = 1'b0;
    cyc(CPB);
    send(8'h07, 1'b1, 1'b1);
    cyc(4);
    chk("par_err_count", 32'(pe_n), 1);
    chk("par_rx_count", 32'(rx_count), 0);
    chk("par_no_frame_err", 32'(fe_n), 1);
`endif

    // Asynchronous reset in the middle of data bit 3 with three words still queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("mid_tx_count", 32'(tx_count), 3);
    cyc(4 * CPB + CPB / 2 - 3);
    chk("mid_data_bit3", 32'(serial_out), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_serial_out", 32'(serial_out), 1);
    chk("mid_rst_tx_count", 32'(tx_count), 0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_tx_ready_pre", 32'(tx_ready), 0);
    cyc(1);
    chk("mid_rel_tx_ready_post", 32'(tx_ready), 1);
    cyc(2 * CPB);
    chk("mid_rel_line_idle", 32'(serial_out), 1);
    chk("mid_rel_tx_count", 32'(tx_count), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
